// File: rtl/fanout_fork_tx.sv
// ============================================================================
// fanout_fork_tx : eager fork broadcasting one valid/ready stream to NUM_OUT
//                  consumers, with per-consumer sticky taken bits.
// Optional: FANOUT_FORK_STALL_CNT_EN adds a saturating stall counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module fanout_fork_tx #(
  parameter int NUM_OUT = 9,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               flush,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_OUT-1:0] out_en,
  input  logic [NUM_OUT-1:0] out_sel,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready
`ifdef FANOUT_FORK_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  logic [DATA_W-1:0]  data_q, data_d;
  logic               full_q, full_d;
  logic [NUM_OUT-1:0] part_q, part_d;
  logic [NUM_OUT-1:0] taken_q, taken_d;

  logic w_retire;
  logic w_load;

  assign out_valid = {NUM_OUT{full_q}} & part_q & ~taken_q;
  assign out_data  = data_q;

  // A consumer is done if it is not participating, already took it, or takes it now.
  assign w_retire = full_q & (&(~part_q | taken_q | out_ready));
  assign in_ready = clk_en & (~full_q | w_retire);
  assign w_load   = in_valid & in_ready;

  always_comb begin
    data_d  = data_q;
    full_d  = full_q;
    part_d  = part_q;
    taken_d = taken_q;
    if (flush) begin
      data_d  = '0;
      full_d  = 1'b0;
      part_d  = '0;
      taken_d = '0;
    end else if (w_load) begin
      data_d  = in_data;
      full_d  = 1'b1;
      part_d  = out_en & out_sel;
      taken_d = '0;
    end else if (w_retire) begin
      full_d  = 1'b0;
      taken_d = '0;
    end else if (full_q) begin
      taken_d = taken_q | (out_valid & out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      part_q  <= '0;
      taken_q <= '0;
    end else if (clk_en) begin
      data_q  <= data_d;
      full_q  <= full_d;
      part_q  <= part_d;
      taken_q <= taken_d;
    end
  end

`ifdef FANOUT_FORK_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (full_q && !w_retire && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (clk_en) begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/fanout_fork_tx.md
Name: fanout_fork_tx

Overview:
- Producer-side eager fork for the streaming fabric: one upstream valid/ready stream is broadcast to up to N downstream consumers.
- Each consumer is individually enabled and selected. Per-consumer sticky "taken" bits ensure every participating consumer receives each token exactly once.
- Upstream ready is released only when all participants have accepted the token.
- It is the transmit end of the fanout-ready aggregation path: it generates the per-destination valids that the ready-side hash consumes.

Parameters:
- NUM_OUT, 9, number of downstream consumers (1..16)
- DATA_W, 32, payload width in bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  clock enable; when 0, all state holds
- flush  in  1  synchronous clear (effective when clk_en=1); same effect as reset
- in_data  in  DATA_W  upstream payload
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_en  in  NUM_OUT  per-consumer enable (E)
- out_sel  in  NUM_OUT  per-consumer config select bit (S)
- out_data  out  DATA_W  broadcast payload (from hold register)
- out_valid  out  NUM_OUT  per-consumer valid
- out_ready  in  NUM_OUT  per-consumer ready (I)

Behaviour:
- State:
  - hold register data_q[DATA_W]
  - full_q
  - participant mask part_q[NUM_OUT]
  - taken mask taken_q[NUM_OUT]
- Reset/flush: full_q=0, taken_q=0, part_q=0, data_q=0. Hence out_valid=0, out_data=0, in_ready=1.
- Reset mid-token: the token is discarded; no partial delivery is retained.
- out_valid[i] = full_q & part_q[i] & ~taken_q[i]. out_data = data_q.
- Delivery to consumer i: out_valid[i] & out_ready[i].
- retire = full_q & AND over i of (~part_q[i] | taken_q[i] | out_ready[i]).
- in_ready = ~full_q | retire. This is combinational and allows one token per cycle at full throughput.
- Load: when in_valid & in_ready & clk_en:
  - data_q <= in_data, full_q <= 1, part_q <= out_en & out_sel, taken_q <= 0.
  - Latency in_valid to out_valid: 1 cycle.
- Retire without load: full_q <= 0, taken_q <= 0.
- Otherwise while full: taken_q[i] <= taken_q[i] | (out_valid[i] & out_ready[i]).
- Participant mask is latched at load. Changes to out_en/out_sel while a token is held do not affect that token and apply from the next load.
- Zero participants (part_q=0): the token retires in the first cycle it is held with no out_valid asserted, i.e. it is dropped, and in_ready=1 that cycle.
- Simultaneous retire and load: the new token overwrites the hold register in the same edge; no bubble.
- Consumer i that has taken the token holds out_valid[i]=0 until the next token, even if others stall. A taken consumer's out_ready is ignored.
- clk_en=0: no state update; combinational outputs still reflect held state. in_ready is forced to 0 so no upstream handshake is counted.

Optional Feature:
- Macro FANOUT_FORK_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0], a saturating counter, reset/flush to 0, incremented on each clk_en cycle where full_q=1 and retire=0. It saturates at 16'hFFFF with no wrap.
- Not defined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Broadcast, all ready: out_en=9'h1FF, out_sel=9'h1FF, out_ready all 1, feed 0xA5A5_0001..0004 back-to-back.
  - Required: each token appears on out_data one cycle after acceptance with out_valid=9'h1FF.
  - in_ready stays 1; 4 tokens in 4 cycles.
- Staggered accept: mask 9'h007; consumer 0 ready in cycle 1, consumer 1 in cycle 2, consumer 2 in cycle 4.
  - Required: out_valid goes 7 -> 6 -> 4 -> 4 -> 0.
  - in_ready=1 only in cycle 4; no duplicate delivery to 0 or 1.
- Zero participants: out_sel=0, push 0x1234.
  - Required: out_valid stays 0; token dropped after 1 held cycle; in_ready=1 throughout.
- Mask change mid-token: load with mask 9'h003, consumer 1 stalled; switch out_en to 9'h100.
  - Required: out_valid stays 9'h002 until consumer 1 accepts.
  - The next token uses mask 9'h100.
- Async reset mid-token: assert rst_n=0 while full with taken_q=9'h001.
  - Required: out_valid=0 and in_ready=1 immediately.
  - After release, the first push delivers to all participants.
- With FANOUT_FORK_STALL_CNT_EN: hold one participant unready for 70000 cycles.
  - Required: stall_cnt saturates at 0xFFFF; flush returns it to 0.
